list_store: RTL and testbench

- Responder end of the list op_sel/op_en command interface: the block that owns list storage and executes Read, Insert, Find_all_index, Find_1st_index, Sum, Sort_Asc, Sort_Des and Delete for an initiator (bench or controller).
- Register-array list of up to LENGTH entries, kept packed in indices 0..len-1.
- Results are returned on data_out, qualified by op_done and op_error.

---
 rtl/list_pkg.sv | 36 +++
 rtl/list_if.sv | 32 +++
 rtl/list_sum.sv | 74 +++++++
 rtl/list_store.sv | 233 +++++++++++++++++++++++
 tb/tb_list_store.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/list_pkg.sv
// Shared opcodes, FSM states and width helpers for the list storage block.
package list_pkg;

    typedef enum logic [2:0] {
        OP_READ     = 3'd0,
        OP_INSERT   = 3'd1,
        OP_FIND_ALL = 3'd2,
        OP_FIND_1ST = 3'd3,
        OP_SUM      = 3'd4,
        OP_SORT_ASC = 3'd5,
        OP_SORT_DES = 3'd6,
        OP_DELETE   = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SCAN     = 3'd1,
        S_SORT     = 3'd2,
        S_SUM_SEQ  = 3'd3,
        S_SUM_TREE = 3'd4,
        S_WAIT_LOW = 3'd5
    } state_e;

    localparam int unsigned SUM_COMBO = 0;
    localparam int unsigned SUM_SEQ   = 1;
    localparam int unsigned SUM_TREE  = 2;

    function automatic int unsigned idx_width(input int unsigned length);
        return $clog2(length);
    endfunction

    function automatic int unsigned sum_width(input int unsigned data_width, input int unsigned length);
        return data_width + $clog2(length);
    endfunction

endpackage

// File: rtl/list_if.sv
// Command/result bundle between a list initiator and the list_store responder.
interface list_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LENGTH     = 8
);
    import list_pkg::*;

    localparam int unsigned LW  = idx_width(LENGTH);
    localparam int unsigned OW  = sum_width(DATA_WIDTH, LENGTH);
    localparam int unsigned LCW = $clog2(LENGTH + 1);

    op_e                   op_sel;
    logic                  op_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [LW-1:0]         index_in;
    logic [OW-1:0]         data_out;
    logic                  op_done;
    logic                  op_in_progress;
    logic                  op_error;
    logic [LCW-1:0]        len;

    modport master (
        output op_sel, op_en, data_in, index_in,
        input  data_out, op_done, op_in_progress, op_error, len
    );

    modport slave (
        input  op_sel, op_en, data_in, index_in,
        output data_out, op_done, op_in_progress, op_error, len
    );

endinterface

// File: rtl/list_sum.sv
// Sum of the masked list entries; combinational, one-per-cycle, or in-place registered tree.
module list_sum
    import list_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LENGTH     = 8,
    parameter int unsigned SUM_METHOD = SUM_COMBO
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [DATA_WIDTH-1:0]                      elems [LENGTH],
    input  logic [LENGTH-1:0]                          mask,
    output logic                                       done_c,
    output logic [sum_width(DATA_WIDTH, LENGTH)-1:0]   sum_c
);
    localparam int unsigned LW = idx_width(LENGTH);
    localparam int unsigned SW = sum_width(DATA_WIDTH, LENGTH);
    localparam int unsigned CW = LW + 1;

    logic [SW-1:0] masked [LENGTH];
    logic [SW-1:0] combo_sum;
    logic [SW-1:0] acc;
    logic [SW-1:0] tree [LENGTH];
    logic [CW-1:0] cnt;
    logic          busy;

    always_comb begin
        combo_sum = '0;
        for (int i = 0; i < LENGTH; i++) begin
            masked[i] = mask[i] ? SW'(elems[i]) : '0;
            combo_sum = combo_sum + masked[i];
        end
    end

    // Sequential mode stops at the first unmasked slot; tree mode after LW halvings.
    always_comb begin
        done_c = 1'b0;
        sum_c  = combo_sum;
        if (SUM_METHOD == SUM_COMBO) begin
            done_c = start;
        end else if (SUM_METHOD == SUM_SEQ) begin
            sum_c  = acc;
            done_c = busy && ((cnt == CW'(LENGTH)) || !mask[cnt[LW-1:0]]);
        end else begin
            sum_c  = tree[0];
            done_c = busy && (cnt == CW'(LW));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            acc  <= '0;
            for (int i = 0; i < LENGTH; i++) tree[i] <= '0;
        end else if (start && (SUM_METHOD != SUM_COMBO)) begin
            busy <= 1'b1;
            cnt  <= '0;
            acc  <= '0;
            for (int i = 0; i < LENGTH; i++) tree[i] <= masked[i];
        end else if (busy) begin
            if (done_c) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
                acc <= acc + masked[cnt[LW-1:0]];
                for (int i = 0; i < LENGTH / 2; i++) tree[i] <= tree[2*i] + tree[2*i+1];
                for (int i = LENGTH / 2; i < LENGTH; i++) tree[i] <= '0;
            end
        end
    end

endmodule

// File: rtl/list_store.sv
// Responder that owns a packed register list and executes the eight list commands.
module list_store
    import list_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LENGTH     = 8,
    parameter int unsigned SUM_METHOD = SUM_COMBO
) (
    input logic   clk,
    input logic   rst,
    list_if.slave bus
);
    localparam int unsigned LW  = idx_width(LENGTH);
    localparam int unsigned OW  = sum_width(DATA_WIDTH, LENGTH);
    localparam int unsigned LCW = $clog2(LENGTH + 1);

    state_e                state;
    logic [DATA_WIDTH-1:0] mem [LENGTH];
    logic [LCW-1:0]        len_q;
    logic [OW-1:0]         data_out_q;
    logic                  op_done_q;
    logic                  op_error_q;
    logic                  in_prog_q;
    logic                  rearm;
    logic [LW-1:0]         scan_idx;
    logic [LW-1:0]         phase;
    logic [DATA_WIDTH-1:0] scan_val;
    logic                  scan_hit;
    logic                  sort_des;

    logic                  accept_c;
    logic [LCW-1:0]        index_c;
    logic [LCW-1:0]        ins_pos_c;
    logic [LENGTH-1:0]     mask_c;
    logic                  first_hit_c;
    logic [LW-1:0]         first_idx_c;
    logic [LENGTH-2:0]     swap_c;
    logic                  scan_match_c;
    logic                  scan_last_c;
    logic                  sum_start_c;
    logic                  sum_done_c;
    logic [OW-1:0]         sum_c;

    always_comb begin
        accept_c     = (state == S_IDLE) && bus.op_en && rearm;
        index_c      = LCW'(bus.index_in);
        ins_pos_c    = (index_c > len_q) ? len_q : index_c;
        sum_start_c  = accept_c && (bus.op_sel == OP_SUM);
        scan_match_c = (mem[scan_idx] == scan_val);
        scan_last_c  = (LCW'(scan_idx) == (len_q - 1'b1));
        mask_c       = '0;
        first_hit_c  = 1'b0;
        first_idx_c  = '0;
        for (int i = 0; i < LENGTH; i++) begin
            mask_c[i] = (LCW'(i) < len_q);
            if (mask_c[i] && !first_hit_c && (mem[i] == bus.data_in)) begin
                first_hit_c = 1'b1;
                first_idx_c = LW'(i);
            end
        end
        // Odd-even transposition: pairs (j, j+1) with j matching the phase parity.
        swap_c = '0;
        for (int j = 0; j < LENGTH - 1; j++) begin
            swap_c[j] = (1'(j) == phase[0]) && mask_c[j+1] &&
                        (sort_des ? (mem[j] < mem[j+1]) : (mem[j] > mem[j+1]));
        end
    end

    list_sum #(
        .DATA_WIDTH (DATA_WIDTH),
        .LENGTH     (LENGTH),
        .SUM_METHOD (SUM_METHOD)
    ) u_sum (
        .clk    (clk),
        .rst    (rst),
        .start  (sum_start_c),
        .elems  (mem),
        .mask   (mask_c),
        .done_c (sum_done_c),
        .sum_c  (sum_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            len_q      <= '0;
            data_out_q <= '0;
            op_done_q  <= 1'b0;
            op_error_q <= 1'b0;
            in_prog_q  <= 1'b0;
            rearm      <= 1'b1;
            scan_idx   <= '0;
            phase      <= '0;
            scan_val   <= '0;
            scan_hit   <= 1'b0;
            sort_des   <= 1'b0;
            for (int i = 0; i < LENGTH; i++) mem[i] <= '0;
        end else begin
            op_done_q  <= 1'b0;
            op_error_q <= 1'b0;
            case (state)
                S_IDLE: if (accept_c) begin
                    case (bus.op_sel)
                        OP_READ: begin
                            op_done_q <= 1'b1;
                            if (index_c >= len_q) op_error_q <= 1'b1;
                            else                  data_out_q <= OW'(mem[bus.index_in]);
                        end
                        OP_INSERT: begin
                            op_done_q <= 1'b1;
                            rearm     <= 1'b0;
                            state     <= S_WAIT_LOW;
                            if (len_q == LCW'(LENGTH)) begin
                                op_error_q <= 1'b1;
                            end else begin
                                for (int i = 1; i < LENGTH; i++)
                                    if ((LCW'(i) > ins_pos_c) && (LCW'(i) <= len_q)) mem[i] <= mem[i-1];
                                mem[LW'(ins_pos_c)] <= bus.data_in;
                                len_q <= len_q + 1'b1;
                            end
                        end
                        OP_DELETE: begin
                            op_done_q <= 1'b1;
                            rearm     <= 1'b0;
                            state     <= S_WAIT_LOW;
                            if (index_c >= len_q) begin
                                op_error_q <= 1'b1;
                            end else begin
                                for (int i = 0; i < LENGTH - 1; i++)
                                    if ((LCW'(i) >= index_c) && (LCW'(i + 1) < len_q)) mem[i] <= mem[i+1];
                                mem[LW'(len_q - 1'b1)] <= '0;
                                len_q <= len_q - 1'b1;
                            end
                        end
                        OP_FIND_1ST: begin
                            op_done_q <= 1'b1;
                            rearm     <= 1'b0;
                            state     <= S_WAIT_LOW;
                            if (first_hit_c) data_out_q <= OW'(first_idx_c);
                            else             op_error_q <= 1'b1;
                        end
                        OP_FIND_ALL: begin
                            if (len_q == '0) begin
                                op_done_q  <= 1'b1;
                                op_error_q <= 1'b1;
                                rearm      <= 1'b0;
                                state      <= S_WAIT_LOW;
                            end else begin
                                in_prog_q <= 1'b1;
                                scan_idx  <= '0;
                                scan_hit  <= 1'b0;
                                scan_val  <= bus.data_in;
                                state     <= S_SCAN;
                            end
                        end
                        OP_SUM: begin
                            if (SUM_METHOD == SUM_COMBO) begin
                                op_done_q  <= 1'b1;
                                data_out_q <= sum_c;
                                rearm      <= 1'b0;
                                state      <= S_WAIT_LOW;
                            end else begin
                                in_prog_q <= 1'b1;
                                state     <= (SUM_METHOD == SUM_SEQ) ? S_SUM_SEQ : S_SUM_TREE;
                            end
                        end
                        OP_SORT_ASC, OP_SORT_DES: begin
                            in_prog_q <= 1'b1;
                            phase     <= '0;
                            sort_des  <= (bus.op_sel == OP_SORT_DES);
                            state     <= S_SORT;
                        end
                    endcase
                end
                S_SCAN: begin
                    if (scan_match_c) begin
                        op_done_q  <= 1'b1;
                        data_out_q <= OW'(scan_idx);
                        scan_hit   <= 1'b1;
                    end
                    if (scan_last_c) begin
                        in_prog_q <= 1'b0;
                        rearm     <= 1'b0;
                        state     <= S_WAIT_LOW;
                        if (!scan_hit && !scan_match_c) begin
                            op_done_q  <= 1'b1;
                            op_error_q <= 1'b1;
                        end
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                S_SORT: begin
                    for (int j = 0; j < LENGTH - 1; j++)
                        if (swap_c[j]) begin
                            mem[j]   <= mem[j+1];
                            mem[j+1] <= mem[j];
                        end
                    phase <= phase + 1'b1;
                    if (phase == LW'(LENGTH - 1)) begin
                        op_done_q <= 1'b1;
                        in_prog_q <= 1'b0;
                        rearm     <= 1'b0;
                        state     <= S_WAIT_LOW;
                    end
                end
                S_SUM_SEQ, S_SUM_TREE: begin
                    if (sum_done_c) begin
                        op_done_q  <= 1'b1;
                        data_out_q <= sum_c;
                        in_prog_q  <= 1'b0;
                        rearm      <= 1'b0;
                        state      <= S_WAIT_LOW;
                    end
                end
                S_WAIT_LOW: begin
                    if (!bus.op_en) begin
                        rearm <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.data_out       = data_out_q;
    assign bus.op_done        = op_done_q;
    assign bus.op_error       = op_error_q;
    assign bus.op_in_progress = in_prog_q;
    assign bus.len            = len_q;

endmodule

// File: tb/tb_list_store.sv
// Scoreboard bench: three list_store copies (one per sum method) fed identical commands.
module tb_list_store;
    import list_pkg::*;

    localparam int unsigned DW   = 8;
    localparam int unsigned LEN  = 8;
    localparam int unsigned LW   = 3;
    localparam int unsigned OW   = 11;
    localparam int unsigned LCW  = 4;
    localparam int unsigned NDUT = 3;

    typedef struct {
        logic [OW-1:0] data;
        logic          err;
        logic          chk;
        int            step;
    } rsp_t;

    logic           clk;
    logic           rst;
    op_e            op_sel;
    logic           op_en;
    logic [DW-1:0]  data_in;
    logic [LW-1:0]  index_in;

    logic [OW-1:0]  dout_w [NDUT];
    logic           done_w [NDUT];
    logic           err_w  [NDUT];
    logic           prog_w [NDUT];
    logic [LCW-1:0] len_w  [NDUT];

    rsp_t exp_q [NDUT][$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : u
        list_if #(.DATA_WIDTH(DW), .LENGTH(LEN)) bus ();

        list_store #(.DATA_WIDTH(DW), .LENGTH(LEN), .SUM_METHOD(g)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );

        assign bus.op_sel   = op_sel;
        assign bus.op_en    = op_en;
        assign bus.data_in  = data_in;
        assign bus.index_in = index_in;
        assign dout_w[g]    = bus.data_out;
        assign done_w[g]    = bus.op_done;
        assign err_w[g]     = bus.op_error;
        assign prog_w[g]    = bus.op_in_progress;
        assign len_w[g]     = bus.len;

        // Monitor: every op_done strobe must match the oldest pending expectation.
        always @(negedge clk) begin
            rsp_t r;
            if (bus.op_done) begin
                total++;
                if (exp_q[g].size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done dut%0d data=%0d err=%0d", g, bus.data_out, bus.op_error);
                end else begin
                    r = exp_q[g].pop_front();
                    if ((bus.op_error !== r.err) || (r.chk && (bus.data_out !== r.data))) begin
                        bad++;
                        $display("FAIL rsp step%0d dut%0d got data=%0d err=%0d exp data=%0d err=%0d",
                                 r.step, g, bus.data_out, bus.op_error, r.data, r.err);
                    end
                end
            end
        end
    end

    task automatic expect_rsp(input int step, input int data, input bit err, input bit chk);
        rsp_t r;
        r.data = OW'(data);
        r.err  = err;
        r.chk  = chk;
        r.step = step;
        for (int g = 0; g < NDUT; g++) exp_q[g].push_back(r);
    endtask

    function automatic bit all_quiet();
        for (int g = 0; g < NDUT; g++)
            if ((exp_q[g].size() != 0) || prog_w[g]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_quiet(input int step);
        int n = 0;
        while (!all_quiet() && (n < 200)) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!all_quiet()) begin
            total++;
            bad++;
            $display("FAIL timeout step%0d pending=%0d", step, exp_q[0].size());
            for (int g = 0; g < NDUT; g++) exp_q[g].delete();
        end
    endtask

    task automatic cmd(input int step, input op_e op, input int idx, input int dat, input int hold = 0);
        @(negedge clk);
        op_sel   = op;
        index_in = LW'(idx);
        data_in  = DW'(dat);
        op_en    = 1'b1;
        wait_quiet(step);
        repeat (hold) @(negedge clk);
        op_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Level-triggered read of indices 0..n-1; reads past nval expect an error with data held.
    task automatic read_burst(input int step, input int n, input int nval, input int v [8]);
        int last = 0;
        @(negedge clk);
        op_sel = OP_READ;
        op_en  = 1'b1;
        for (int k = 0; k < n; k++) begin
            index_in = LW'(k);
            if (k < nval) begin
                expect_rsp(step, v[k], 1'b0, 1'b1);
                last = v[k];
            end else begin
                expect_rsp(step, last, 1'b1, 1'b1);
            end
            @(negedge clk);
        end
        op_en = 1'b0;
        wait_quiet(step);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_len(input int step, input int exp);
        for (int g = 0; g < NDUT; g++) begin
            total++;
            if (len_w[g] !== LCW'(exp)) begin
                bad++;
                $display("FAIL len step%0d dut%0d got=%0d exp=%0d", step, g, len_w[g], exp);
            end
        end
    endtask

    task automatic chk_zero(input int step);
        for (int g = 0; g < NDUT; g++) begin
            total++;
            if ((dout_w[g] !== '0) || (done_w[g] !== 1'b0) || (err_w[g] !== 1'b0) ||
                (prog_w[g] !== 1'b0) || (len_w[g] !== '0)) begin
                bad++;
                $display("FAIL reset_state step%0d dut%0d data=%0d done=%0d err=%0d prog=%0d len=%0d exp all 0",
                         step, g, dout_w[g], done_w[g], err_w[g], prog_w[g], len_w[g]);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        op_en    = 1'b0;
        op_sel   = OP_READ;
        data_in  = '0;
        index_in = '0;
        repeat (3) @(negedge clk);
        chk_zero(0);
        rst = 1'b0;

        expect_rsp(1, 0, 1'b0, 1'b0); cmd(1, OP_INSERT, 0, 10);
        expect_rsp(2, 0, 1'b0, 1'b0); cmd(2, OP_INSERT, 1, 20);
        expect_rsp(3, 0, 1'b0, 1'b0); cmd(3, OP_INSERT, 5, 30);
        chk_len(3, 3);
        read_burst(4, 3, 3, '{10, 20, 30, 0, 0, 0, 0, 0});
        expect_rsp(5, 0, 1'b0, 1'b0); cmd(5, OP_INSERT, 1, 10);
        chk_len(5, 4);
        read_burst(6, 5, 4, '{10, 10, 20, 30, 0, 0, 0, 0});

        expect_rsp(7, 0, 1'b1, 1'b0); cmd(7, OP_DELETE, 7, 0);
        chk_len(7, 4);
        expect_rsp(8, 0, 1'b0, 1'b0); cmd(8, OP_DELETE, 2, 0);
        chk_len(8, 3);
        read_burst(9, 3, 3, '{10, 10, 30, 0, 0, 0, 0, 0});

        expect_rsp(10, 50, 1'b0, 1'b1); cmd(10, OP_SUM, 0, 0);
        expect_rsp(11, 0, 1'b0, 1'b0); cmd(11, OP_SORT_DES, 0, 0);
        read_burst(12, 3, 3, '{30, 10, 10, 0, 0, 0, 0, 0});
        expect_rsp(13, 0, 1'b0, 1'b0); cmd(13, OP_SORT_ASC, 0, 0, 20);
        read_burst(14, 3, 3, '{10, 10, 30, 0, 0, 0, 0, 0});
        chk_len(14, 3);

        expect_rsp(15, 0, 1'b0, 1'b1);
        expect_rsp(15, 1, 1'b0, 1'b1);
        cmd(15, OP_FIND_ALL, 0, 10);
        expect_rsp(16, 0, 1'b1, 1'b0); cmd(16, OP_FIND_ALL, 0, 77);
        expect_rsp(17, 2, 1'b0, 1'b1); cmd(17, OP_FIND_1ST, 0, 30);
        expect_rsp(18, 0, 1'b1, 1'b0); cmd(18, OP_FIND_1ST, 0, 77);

        for (int k = 0; k < 5; k++) begin
            expect_rsp(19, 0, 1'b0, 1'b0);
            cmd(19, OP_INSERT, 7, 41 + k);
        end
        chk_len(19, 8);
        expect_rsp(20, 0, 1'b1, 1'b0); cmd(20, OP_INSERT, 0, 99);
        chk_len(20, 8);
        read_burst(21, 8, 8, '{10, 10, 30, 41, 42, 43, 44, 45});
        expect_rsp(22, 265, 1'b0, 1'b1); cmd(22, OP_SUM, 0, 0);
        expect_rsp(23, 0, 1'b0, 1'b0); cmd(23, OP_SORT_DES, 0, 0);
        read_burst(24, 8, 8, '{45, 44, 43, 42, 41, 30, 10, 10});

        // Reset in the middle of a sort: no completion strobe may follow.
        @(negedge clk);
        op_sel = OP_SORT_ASC;
        op_en  = 1'b1;
        repeat (3) @(negedge clk);
        rst   = 1'b1;
        op_en = 1'b0;
        @(negedge clk);
        chk_zero(25);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk_len(26, 0);

        expect_rsp(27, 0, 1'b0, 1'b1); cmd(27, OP_SUM, 0, 0);
        expect_rsp(28, 0, 1'b1, 1'b0); cmd(28, OP_FIND_ALL, 0, 5);

        for (int g = 0; g < NDUT; g++) begin
            total++;
            if (exp_q[g].size() != 0) begin
                bad++;
                $display("FAIL leftover dut%0d pending=%0d exp=0", g, exp_q[g].size());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
